logic_gate_sweeper: RTL
=======================

// Module: logic_gate_sweeper
// PURPOSE
//  Parametrised, registered two-operand bitwise logic unit with an op select.
//  Two modes:
//   - Direct: evaluates one supplied operand pair.
//   - Sweep: internally enumerates every {a,b} combination and streams each result.
//  Replaces the hand-written per-gate truth-table benches in the lab flow.
//  Feeds the result checker over a valid/ready stream.
// PARAMETERS
//  WIDTH  1  operand/result width in bits; legal 1..8
//  OPW    3  op select width; fixed at 3
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  op         in   OPW      operation select (encoding below)
//  start      in   1        request a sweep; sampled in IDLE only
//  in_valid   in   1        direct operand pair present
//  in_ready   out  1        direct pair accepted when in_valid & in_ready
//  a          in   WIDTH    direct operand a
//  b          in   WIDTH    direct operand b
//  out_valid  out  1        result register holds a beat
//  out_ready  in   1        consumer accepts the beat when out_valid & out_ready
//  out_a      out  WIDTH    operand a that produced s
//  out_b      out  WIDTH    operand b that produced s
//  s          out  WIDTH    result
//  busy       out  1        high while a sweep is in progress (state != IDLE)
//  done       out  1        one-cycle pulse after the last sweep beat is accepted
// BEHAVIOUR
//  Op encoding (bitwise, per bit):
//   0 AND   1 OR   2 NAND   3 NOR   4 XOR   5 XNOR   6 NOT a   7 BUF a
//  Reset: asynchronous. All outputs, the state and the counter go to 0; state=IDLE.
//   Applies equally mid-sweep; no beat survives reset.
//  Output register: single entry.
//   - load_ok = !out_valid | out_ready.
//   - While out_valid & !out_ready: out_a, out_b and s are held stable.
//  FSM IDLE -> SWEEP -> DRAIN -> IDLE.
//  IDLE:
//   - in_ready = !start & load_ok (combinational).
//   - Accepted pair: registers {a, b, f(op,a,b)}; out_valid=1 on the next edge.
//     Latency is 1 cycle. op is sampled with the pair.
//   - start=1: latches op into op_q, clears cnt, goes to SWEEP.
//   - start and in_valid together: start wins. The pair is not taken (in_ready=0).
//  SWEEP:
//   - in_ready=0; start is ignored.
//   - cnt is 2*WIDTH bits; {a,b}=cnt, with a = upper half.
//   - On each cycle with load_ok: load {cnt_a, cnt_b, f(op_q,..)} and increment cnt.
//   - After loading cnt = all ones: go to DRAIN.
//   - Order is 00,01,10,11... Exactly 2^(2*WIDTH) beats; none skipped or repeated.
//  DRAIN:
//   - Waits for the last beat to be accepted (out_valid & out_ready).
//   - Then goes to IDLE, and done=1 for exactly one cycle.
//  The first sweep beat appears 2 edges after start is sampled.
//  With out_ready held high, the sweep produces one beat per cycle.
//  busy: 1 from the edge that leaves IDLE until the edge that returns to IDLE.
//  No arithmetic beyond the cnt increment. cnt wrap is never reached: DRAIN exits first.
// STRUCTURE
//  Package logic_gate_sweeper_pkg holds:
//   - the OP_* localparams (3-bit encoding above);
//   - the state encodings ST_IDLE / ST_SWEEP / ST_DRAIN (2 bits).
//  Sub-module logic_op_comb (op, a, b -> s):
//   - purely combinational;
//   - a generate loop of per-bit gate primitives plus an op mux;
//   - instantiated once, with its input muxed between direct and sweep operands.
// TESTING
//  1 WIDTH=1, op=AND, out_ready=1, pulse start:
//    beats (a,b,s) = (0,0,0),(0,1,0),(1,0,0),(1,1,1) on consecutive cycles;
//    done pulses once, 1 cycle after the 4th beat; busy then falls.
//  2 WIDTH=1, op=NAND sweep, out_ready=0 for 3 cycles while beat 2 (0,1,1) is shown:
//    outputs hold; the sweep then resumes with (1,0,1),(1,1,0); exactly 4 beats total.
//  3 WIDTH=4 direct, op=XOR, a=4'hA, b=4'h6:
//    s=4'hC with out_valid=1 after 1 edge;
//    then op=NAND, a=4'hF, b=4'hF -> s=4'h0.
//  4 start=1 and in_valid=1 in the same IDLE cycle:
//    in_ready=0, pair not taken, sweep starts;
//    in_valid held through the sweep is accepted only after the return to IDLE.
//  5 WIDTH=2, op=NOR sweep:
//    16 beats, each s = ~(a|b), in order {a,b}=0..15;
//    an op change mid-sweep has no effect (op_q is used);
//    a second start while busy is ignored.
//  6 rst=1 asynchronously at beat 3 of a WIDTH=2 sweep:
//    out_valid, busy, done, s, out_a, out_b = 0 immediately;
//    a new start afterwards restarts from {a,b}=0.

Source files
------------

// File: rtl/logic_gate_sweeper_pkg.sv
// Shared op encodings and FSM states for the logic gate sweeper.
package logic_gate_sweeper_pkg;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_NAND  = 3'd2;
   localparam logic [2:0] OP_NOR   = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_XNOR  = 3'd5;
   localparam logic [2:0] OP_NOT_A = 3'd6;
   localparam logic [2:0] OP_BUF_A = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/logic_gate_sweeper_op.sv
// Combinational bitwise logic unit: per-bit gate primitives followed by an op mux.
module logic_op_comb
   import logic_gate_sweeper_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned OPW   = 3
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s
);

   logic [WIDTH-1:0] and_w;
   logic [WIDTH-1:0] or_w;
   logic [WIDTH-1:0] xor_w;
   logic [WIDTH-1:0] not_w;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      and u_and (and_w[i], a[i], b[i]);
      or  u_or  (or_w[i],  a[i], b[i]);
      xor u_xor (xor_w[i], a[i], b[i]);
      not u_not (not_w[i], a[i]);
   end

   always_comb begin
      s = '0;
      case (op)
         OP_AND:   s = and_w;
         OP_OR:    s = or_w;
         OP_NAND:  s = ~and_w;
         OP_NOR:   s = ~or_w;
         OP_XOR:   s = xor_w;
         OP_XNOR:  s = ~xor_w;
         OP_NOT_A: s = not_w;
         OP_BUF_A: s = a;
         default:  s = '0;
      endcase
   end

endmodule

// File: rtl/logic_gate_sweeper.sv
// Registered two-operand logic unit: evaluates one direct pair, or sweeps every
// {a,b} combination and streams the results over a single-entry valid/ready register.
module logic_gate_sweeper
   import logic_gate_sweeper_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned OPW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPW-1:0]   op,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] s,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = 2 * WIDTH;

   state_t           state_q, state_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             done_q, done_d;

   logic             sweeping;
   logic             load_ok;
   logic             load;
   logic             in_ready_c;
   logic [OPW-1:0]   f_op;
   logic [WIDTH-1:0] f_a, f_b, f_s;

   // One evaluator shared by both modes; the sweep counter supplies operands while sweeping.
   assign sweeping = (state_q == ST_SWEEP);
   assign load_ok  = !out_valid_q || out_ready;
   assign f_op     = sweeping ? op_q : op;
   assign f_a      = sweeping ? cnt_q[CW-1:WIDTH] : a;
   assign f_b      = sweeping ? cnt_q[WIDTH-1:0] : b;

   logic_op_comb #(
      .WIDTH (WIDTH),
      .OPW   (OPW)
   ) u_op (
      .op (f_op),
      .a  (f_a),
      .b  (f_b),
      .s  (f_s)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q && !out_ready;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      s_d         = s_q;
      done_d      = 1'b0;
      load        = 1'b0;
      in_ready_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready_c = !start && load_ok;
            if (start) begin
               op_d    = op;
               cnt_d   = '0;
               state_d = ST_SWEEP;
            end else if (in_valid && in_ready_c) begin
               load = 1'b1;
            end
         end
         ST_SWEEP: begin
            if (load_ok) begin
               load = 1'b1;
               // Stop at all-ones instead of wrapping so the count stays on the last pair.
               if (cnt_q == '1) begin
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && out_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         out_valid_d = 1'b1;
         out_a_d     = f_a;
         out_b_d     = f_b;
         s_d         = f_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         s_q         <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         s_q         <= s_d;
         done_q      <= done_d;
      end
   end

   // Held low during reset so every output reads 0 while rst is asserted.
   assign in_ready  = in_ready_c && !rst;
   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign s         = s_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule
